// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C command sequencer: expands one START/WRITE/READ/STOP register command
// into single-bit commands for the SCL/SDA bit engine and reports completion or arbitration loss.
module i2c_byte_sequencer (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       wb_rst_i,
    input  logic       ena,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       i2c_al,
    output logic [3:0] bit_cmd,
    output logic       bit_txd,
    input  logic       bit_ack,
    input  logic       bit_rxd,
    input  logic       bit_al
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] sr, sr_nxt;
    logic [2:0] dcnt, dcnt_nxt;
    logic [3:0] bit_cmd_nxt;
    logic       bit_txd_nxt;
    logic       cmd_ack_nxt;
    logic       ack_out_nxt;
    logic       i2c_al_nxt;
    logic       go;

    // cmd_ack gates go so the still-held command is not relaunched during the done pulse
    assign go   = (cmd_read | cmd_write | cmd_stop) & ~cmd_ack & ena;
    assign dout = sr;

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= ST_IDLE;
            sr      <= 8'h00;
            dcnt    <= 3'd0;
            bit_cmd <= CMD_NOP;
            bit_txd <= 1'b0;
            cmd_ack <= 1'b0;
            ack_out <= 1'b0;
            i2c_al  <= 1'b0;
        end else if (wb_rst_i) begin
            state   <= ST_IDLE;
            sr      <= 8'h00;
            dcnt    <= 3'd0;
            bit_cmd <= CMD_NOP;
            bit_txd <= 1'b0;
            cmd_ack <= 1'b0;
            ack_out <= 1'b0;
            i2c_al  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            dcnt    <= dcnt_nxt;
            bit_cmd <= bit_cmd_nxt;
            bit_txd <= bit_txd_nxt;
            cmd_ack <= cmd_ack_nxt;
            ack_out <= ack_out_nxt;
            i2c_al  <= i2c_al_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        dcnt_nxt    = dcnt;
        bit_cmd_nxt = bit_cmd;
        bit_txd_nxt = bit_txd;
        cmd_ack_nxt = 1'b0;
        ack_out_nxt = ack_out;
        i2c_al_nxt  = 1'b0;

        // Arbitration loss and disable both abandon the byte but keep sr and ack_out
        if (bit_al) begin
            state_nxt   = ST_IDLE;
            bit_cmd_nxt = CMD_NOP;
            i2c_al_nxt  = 1'b1;
        end else if (!ena) begin
            state_nxt   = ST_IDLE;
            bit_cmd_nxt = CMD_NOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        sr_nxt   = din;
                        dcnt_nxt = 3'd7;
                        if (cmd_start) begin
                            state_nxt   = ST_START;
                            bit_cmd_nxt = CMD_START;
                        end else if (cmd_read) begin
                            state_nxt   = ST_READ;
                            bit_cmd_nxt = CMD_READ;
                        end else if (cmd_write) begin
                            state_nxt   = ST_WRITE;
                            bit_cmd_nxt = CMD_WRITE;
                            bit_txd_nxt = din[7];
                        end else begin
                            state_nxt   = ST_STOP;
                            bit_cmd_nxt = CMD_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (bit_ack) begin
                        if (cmd_read) begin
                            state_nxt   = ST_READ;
                            bit_cmd_nxt = CMD_READ;
                        end else begin
                            state_nxt   = ST_WRITE;
                            bit_cmd_nxt = CMD_WRITE;
                            bit_txd_nxt = sr[7];
                        end
                    end
                end
                ST_WRITE: begin
                    if (bit_ack) begin
                        if (dcnt != 3'd0) begin
                            sr_nxt      = {sr[6:0], 1'b0};
                            dcnt_nxt    = dcnt - 3'd1;
                            bit_txd_nxt = sr[6];
                        end else begin
                            state_nxt   = ST_ACK;
                            bit_cmd_nxt = CMD_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (bit_ack) begin
                        sr_nxt = {sr[6:0], bit_rxd};
                        if (dcnt != 3'd0) begin
                            dcnt_nxt = dcnt - 3'd1;
                        end else begin
                            state_nxt   = ST_ACK;
                            bit_cmd_nxt = CMD_WRITE;
                            bit_txd_nxt = ack_in;
                        end
                    end
                end
                ST_ACK: begin
                    if (bit_ack) begin
                        // A READ acknowledge phase means we wrote the byte and the slave answered
                        if (bit_cmd == CMD_READ) begin
                            ack_out_nxt = bit_rxd;
                        end
                        if (cmd_stop) begin
                            state_nxt   = ST_STOP;
                            bit_cmd_nxt = CMD_STOP;
                        end else begin
                            state_nxt   = ST_IDLE;
                            bit_cmd_nxt = CMD_NOP;
                            cmd_ack_nxt = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_ack) begin
                        state_nxt   = ST_IDLE;
                        bit_cmd_nxt = CMD_NOP;
                        cmd_ack_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    bit_cmd_nxt = CMD_NOP;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_byte_sequencer.md
# i2c_byte_sequencer

Byte-level command sequencer between the I2C controller register file (control/command, transmit, receive, status registers) and the bit-level SCL/SDA engine. It turns one register-level command (START, WRITE, READ, STOP, plus the ACK bit) into a sequence of single-bit commands. It shifts transmit data out MSB-first, or shifts receive data in. It then completes the acknowledge bit and optional STOP, and pulses a done strobe that the register file uses to clear command bits and set the interrupt flag.

## Interface
Parameters:
- none; byte width fixed at 8, bit-command encoding fixed (NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000)

Ports:
- wb_clk_i  in  1  system clock, all state on rising edge
- arst_i  in  1  reset, asynchronous, active-high
- wb_rst_i  in  1  synchronous reset, active-high, same effect as arst_i
- ena  in  1  core enable (control register EN bit)
- cmd_start  in  1  issue (repeated) START before the byte
- cmd_stop  in  1  issue STOP after the byte (or STOP alone)
- cmd_read  in  1  read a byte
- cmd_write  in  1  write a byte
- ack_in  in  1  ACK value driven after a read (0=ACK, 1=NACK)
- din  in  8  byte to transmit
- cmd_ack  out  1  one-cycle pulse: whole command sequence done
- ack_out  out  1  ACK bit sampled from slave after a write
- dout  out  8  received byte (shift register contents)
- i2c_al  out  1  one-cycle pulse: arbitration lost, sequence aborted
- bit_cmd  out  4  command to bit engine, held until bit_ack
- bit_txd  out  1  data bit for bit-engine WRITE
- bit_ack  in  1  one-cycle pulse: bit engine finished current bit command
- bit_rxd  in  1  bit sampled by bit engine on READ
- bit_al  in  1  arbitration lost, from bit engine

## Operation
- States: IDLE, START, WRITE, READ, ACK, STOP. Shift register sr[7:0] drives dout. Bit counter dcnt[2:0].
- go = (cmd_read | cmd_write | cmd_stop) & !cmd_ack & ena.
- IDLE on go:
  - sr<=din, dcnt<=7.
  - Priority: cmd_start -> START/bit_cmd START; else cmd_read -> READ/bit_cmd READ; else cmd_write -> WRITE/bit_cmd WRITE, bit_txd<=din[7]; else STOP/bit_cmd STOP.
  - cmd_start with no read/write/stop does not launch.
- START, on bit_ack: cmd_read -> READ/READ; else WRITE/WRITE with bit_txd=sr[7].
- WRITE, on bit_ack:
  - dcnt!=0: sr<<=1, dcnt--, bit_txd<=next sr[7], stay.
  - dcnt==0: go to ACK with bit_cmd READ.
- READ, on bit_ack:
  - Always sr<={sr[6:0],bit_rxd}.
  - dcnt!=0: dcnt--, stay.
  - dcnt==0: go to ACK with bit_cmd WRITE, bit_txd=ack_in.
- ACK, on bit_ack:
  - ack_out<=bit_rxd; captured only when the ACK phase was a READ, i.e. after a write.
  - cmd_stop -> STOP/bit_cmd STOP.
  - else -> IDLE, bit_cmd NOP, cmd_ack pulse.
- STOP, on bit_ack: IDLE, bit_cmd NOP, cmd_ack pulse.
- Host holds command inputs and din stable from launch until cmd_ack; it clears command bits in the cycle after cmd_ack.

## Timing
- Reset (arst_i or wb_rst_i) values:
  - state IDLE, sr/dout 8'h00, dcnt 0.
  - bit_cmd 4'h0, bit_txd 0, cmd_ack 0, ack_out 0, i2c_al 0.
- All outputs are registered.
- Launch latency: go sampled at edge N gives bit_cmd valid after edge N.
- Each bit_ack is consumed in the cycle it arrives; the new bit_cmd is visible the next cycle. There are no idle gaps between bits.
- cmd_ack is exactly 1 cycle and is registered in the cycle after the final bit_ack. Because !cmd_ack gates go, the stale command is not relaunched while cmd_ack is high.
- bit_al, in any state:
  - Next state IDLE, bit_cmd NOP, i2c_al 1 for one cycle, cmd_ack 0.
  - bit_al wins over a simultaneous bit_ack.
  - sr and ack_out are held.
- ena low:
  - Forces IDLE, bit_cmd NOP, no cmd_ack, sr held.
  - Mid-byte deassertion aborts silently.
- Reset mid-operation: immediate return to reset values; no cmd_ack or i2c_al pulse.
- Bit count: exactly 8 data bits plus 1 ACK bit per byte; dcnt does not wrap past 0.

## Test plan
- Write with START: din=8'hA5, start+write. Required response:
  - bit_cmd sequence START, WRITE×8 with bit_txd 1,0,1,0,0,1,0,1, then READ.
  - bit_rxd=0 on the ACK bit gives ack_out=0 and a single cmd_ack pulse.
- Read with NACK+STOP: read+stop, ack_in=1, bit_rxd sequence 0,1,1,0,1,0,0,1. Required response:
  - dout=8'h69.
  - ACK phase is a WRITE with bit_txd=1, followed by a STOP command; cmd_ack pulses after the STOP bit_ack.
- STOP only: cmd_stop alone gives bit_cmd STOP, and one cmd_ack pulse one cycle after bit_ack.
- Arbitration loss: bit_al asserted with bit_ack during the 3rd write bit. Required response:
  - i2c_al pulses once, next state IDLE, bit_cmd=0, no cmd_ack.
  - A new command launches normally afterwards.
- Reset mid-read: arst_i pulsed during READ with no clock edge. Required response:
  - All outputs return to reset values immediately; no cmd_ack.
  - The same check holds with wb_rst_i at the next edge.
- ena=0 with cmd_write set: bit_cmd stays 0 indefinitely. Raising ena launches the write the next cycle.
